led_sweep_ctrl: RTL and testbench

Sequencer that exercises the combinational LED decision logic (inputs S, P, V; output L) in-system. On request it drives all 8 {S,P,V} combinations in ascending order and holds each for a programmable dwell. It samples L at the end of each dwell and builds an 8-bit truth table. It compares that table against an expected table and reports pass/fail. It sits between the LED logic instance and the control/status path.

---
 rtl/led_sweep_ctrl_pkg.sv | 15 +
 rtl/led_sweep_ctrl_if.sv | 28 ++
 rtl/led_dwell_timer.sv | 40 ++++
 rtl/led_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_led_sweep_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/led_sweep_ctrl_pkg.sv
// rtl/led_sweep_ctrl_pkg.sv - shared types and sizes for the LED sweep sequencer
package led_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int TT_W    = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/led_sweep_ctrl_if.sv
// rtl/led_sweep_ctrl_if.sv - control/status and LED-drive signals of the sweep sequencer
interface led_sweep_ctrl_if;

    logic       start_i;
    logic       abort_i;
    logic [7:0] expected_i;
    logic       S_o;
    logic       P_o;
    logic       V_o;
    logic       L_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] truth_o;
    logic       mismatch_o;

    // Sequencer side
    modport slave (
        input  start_i, abort_i, expected_i, L_i,
        output S_o, P_o, V_o, busy_o, done_o, truth_o, mismatch_o
    );

    // Host / LED-logic side
    modport master (
        output start_i, abort_i, expected_i, L_i,
        input  S_o, P_o, V_o, busy_o, done_o, truth_o, mismatch_o
    );

endinterface

// File: rtl/led_dwell_timer.sv
// rtl/led_dwell_timer.sv - per-vector dwell counter with terminal count at DWELL-1
module led_dwell_timer
    import led_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load clears the count; enable advances it by one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/led_sweep_ctrl.sv
// rtl/led_sweep_ctrl.sv - sweeps all S/P/V vectors through the LED logic and checks its truth table
module led_sweep_ctrl
    import led_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    led_sweep_ctrl_if.slave         bus
);

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

    state_t            state_q, state_d;
    logic [VEC_W-1:0]  idx_q, idx_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [TT_W-1:0]   truth_q, truth_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic              mis_q, mis_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_tc;

    led_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // State and datapath registers; reset returns everything to idle/zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            truth_q <= '0;
            exp_q   <= '0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            truth_q <= truth_d;
            exp_q   <= exp_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
        end
    end

    // Next state: abort has priority over the final sample of the sweep.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start_i) state_d = ST_APPLY;
            ST_APPLY: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_tc && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: vector drive, truth-table capture, compare and timer control.
    always_comb begin
        idx_d    = idx_q;
        vec_d    = vec_q;
        truth_d  = truth_q;
        exp_d    = exp_q;
        mis_d    = mis_q;
        done_d   = (state_q == ST_DONE);
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vec_d = '0;
                if (bus.start_i) begin
                    idx_d    = '0;
                    truth_d  = '0;
                    mis_d    = 1'b0;
                    exp_d    = bus.expected_i;
                    tmr_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (bus.abort_i) begin
                    vec_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    truth_d[idx_q] = bus.L_i;
                    tmr_load       = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        vec_d = '0;
                        mis_d = ({bus.L_i, truth_q[TT_W-2:0]} != exp_q);
                    end else begin
                        idx_d = idx_q + VEC_W'(1);
                        vec_d = idx_q + VEC_W'(1);
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                vec_d = '0;
            end
        endcase
    end

    assign bus.S_o        = vec_q[2];
    assign bus.P_o        = vec_q[1];
    assign bus.V_o        = vec_q[0];
    assign bus.busy_o     = (state_q == ST_APPLY);
    assign bus.done_o     = done_q;
    assign bus.truth_o    = truth_q;
    assign bus.mismatch_o = mis_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb/tb_led_sweep_ctrl.sv - scoreboard bench for the LED sweep sequencer
module tb_led_sweep_ctrl;

    typedef struct {
        logic [7:0] truth;
        logic       mis;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   sweep_start = 0;
    bit   active = 1'b0;
    exp_t sb[$];

    led_sweep_ctrl_if ifa ();
    led_sweep_ctrl_if ifb ();

    assign ifa.L_i = ifa.S_o & (ifa.P_o | ifa.V_o);
    assign ifb.L_i = ifb.S_o & (ifb.P_o | ifb.V_o);

    led_sweep_ctrl #(.DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    led_sweep_ctrl #(.DWELL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic led_model(input int n);
        return n[2] & (n[1] | n[0]);
    endfunction

    function automatic logic [7:0] model_table();
        logic [7:0] t;
        for (int n = 0; n < 8; n++) t[n] = led_model(n);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [7:0] exp_tt);
        exp_t e;
        ifa.expected_i = exp_tt;
        ifa.start_i = 1'b1;
        tick();
        ifa.start_i = 1'b0;
        sweep_start = cyc;
        active = 1'b1;
        e.truth = model_table();
        e.mis = (model_table() != exp_tt);
        e.cyc = cyc + 33;
        sb.push_back(e);
    endtask

    task automatic full_sweep(input logic [7:0] exp_tt);
        start_sweep(exp_tt);
        repeat (36) tick();
        chk("truth_hold", ifa.truth_o, model_table());
        chk("mis_hold", ifa.mismatch_o, model_table() != exp_tt);
        chk("busy_idle", ifa.busy_o, 1'b0);
    endtask

    task automatic run_abort(input int a);
        logic [7:0] part;
        part = '0;
        for (int n = 0; n < 8; n++) if (4 * (n + 1) < a) part[n] = led_model(n);
        start_sweep(8'hE0);
        repeat (a - 1) tick();
        ifa.abort_i = 1'b1;
        tick();
        ifa.abort_i = 1'b0;
        active = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy", ifa.busy_o, 1'b0);
        chk("abort_vec", {ifa.S_o, ifa.P_o, ifa.V_o}, 3'd0);
        chk("abort_truth", ifa.truth_o, part);
        chk("abort_mis", ifa.mismatch_o, 1'b0);
        repeat (40) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec"}, {ifa.S_o, ifa.P_o, ifa.V_o}, 3'd0);
        chk({tag, "_busy"}, ifa.busy_o, 1'b0);
        chk({tag, "_done"}, ifa.done_o, 1'b0);
        chk({tag, "_truth"}, ifa.truth_o, 8'h00);
        chk({tag, "_mis"}, ifa.mismatch_o, 1'b0);
    endtask

    // Monitor: per-cycle vector/busy checks during a sweep, scoreboard pop on done_o.
    always @(negedge clk) begin
        int k;
        exp_t e;
        if (rst_n) begin
            if (active) begin
                k = cyc - sweep_start;
                if (k >= 0 && k < 32) begin
                    chk("vec", {ifa.S_o, ifa.P_o, ifa.V_o}, 32'(k / 4));
                    chk("busy", ifa.busy_o, 1'b1);
                end
            end
            if (ifa.done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("truth", ifa.truth_o, e.truth);
                    chk("mismatch", ifa.mismatch_o, e.mis);
                end
            end
        end
    end

    initial begin
        int e0;
        int busy_cnt;
        int done_at;
        exp_t e;
        logic [7:0] rexp;
        ifa.start_i = 1'b0; ifa.abort_i = 1'b0; ifa.expected_i = 8'h00;
        ifb.start_i = 1'b0; ifb.abort_i = 1'b0; ifb.expected_i = 8'h00;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        full_sweep(8'hE0);
        full_sweep(8'hF0);
        run_abort(14);

        // Start held from mid-sweep through DONE: one restart at the first IDLE cycle.
        ifa.expected_i = 8'hE0;
        ifa.start_i = 1'b1;
        tick();
        ifa.start_i = 1'b0;
        e0 = cyc;
        sweep_start = cyc;
        active = 1'b1;
        e.truth = model_table(); e.mis = 1'b0; e.cyc = e0 + 33;
        sb.push_back(e);
        repeat (9) tick();
        ifa.start_i = 1'b1;
        while (cyc < e0 + 34) tick();
        ifa.start_i = 1'b0;
        sweep_start = e0 + 34;
        e.cyc = e0 + 34 + 33;
        sb.push_back(e);
        repeat (40) tick();

        // Reset mid-sweep, then a clean sweep.
        start_sweep(8'hE0);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        active = 1'b0;
        void'(sb.pop_back());
        chk_reset_outputs("midreset");
        repeat (3) tick();
        full_sweep(8'hE0);

        // Short-dwell instance.
        ifb.expected_i = 8'hE0;
        ifb.start_i = 1'b1;
        tick();
        ifb.start_i = 1'b0;
        e0 = cyc;
        busy_cnt = ifb.busy_o ? 1 : 0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.busy_o) busy_cnt++;
            if (ifb.done_o && done_at < 0) done_at = cyc - e0;
        end
        chk("d2_busy_cycles", busy_cnt, 16);
        chk("d2_done_cycle", done_at, 17);
        chk("d2_truth", ifb.truth_o, model_table());
        chk("d2_mis", ifb.mismatch_o, 1'b0);

        // Randomized sweeps and aborts.
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 2) == 0) begin
                run_abort(int'($urandom_range(1, 32)));
            end else begin
                rexp = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'($urandom);
                full_sweep(rexp);
            end
        end

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
